// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, valid/ready
// on both the operand and the result side, with divide-by-zero reported as a flag.
module seq_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Quot,
    output logic [N-1:0] Rem,
    output logic         div_by_zero,
    output logic [1:0]   state_dbg
);

    // Handshakes: a transfer happens on a rising clk edge where valid && ready.
    // valid, once raised, stays high until that transfer; ready may toggle freely.

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_next;
    logic [N-1:0]   q_reg;
    logic [N:0]     r_reg;
    logic [N-1:0]   d_reg;
    logic [CW-1:0]  cnt;

    logic [N:0]     r_shift;
    logic [N:0]     r_trial;
    logic           q_bit;
    logic [N:0]     r_next;
    logic [N-1:0]   q_next;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign state_dbg = state;

    // R stays below D between steps, so the shifted remainder always fits in N+1 bits.
    assign r_shift = {r_reg[N-1:0], q_reg[N-1]};
    assign r_trial = r_shift - {1'b0, d_reg};
    assign q_bit   = ~r_trial[N];
    assign r_next  = q_bit ? r_trial : r_shift;
    assign q_next  = {q_reg[N-2:0], q_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = (B == '0) ? DONE : CALC;
            CALC:    if (cnt == '0) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            cnt         <= '0;
            Quot        <= '0;
            Rem         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (B == '0) begin
                            Quot        <= '1;
                            Rem         <= A;
                            div_by_zero <= 1'b1;
                        end else begin
                            q_reg <= A;
                            r_reg <= '0;
                            d_reg <= B;
                            cnt   <= CW'(N - 1);
                        end
                    end
                end
                CALC: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    cnt   <= cnt - CW'(1);
                    if (cnt == '0) begin
                        Quot        <= q_next;
                        Rem         <= r_next[N-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
